// File: rtl/stopwatch_disp.sv
// stopwatch_disp: 4-digit multiplexed 7-segment scanner with frame-latched digits, guard blanking and hold blink
module stopwatch_disp #(
  parameter int SPD = 50_000,
  parameter int GRD = 500,
  parameter int BLK = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sec_0,
  input  logic [6:0] sec_1,
  input  logic [6:0] min_0,
  input  logic [6:0] min_1,
  input  logic       s_run,
  input  logic       s_hld,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int PW = $clog2(SPD);
  localparam int FW = BLK > 1 ? $clog2(BLK) : 1;
  logic [PW-1:0] p;
  logic [1:0]    idx;
  logic [FW-1:0] f;
  logic          phase;
  logic          loaded;
  logic [6:0]    sh_dig [4];
  logic          sh_run;
  logic          sh_hld;
  logic          slot_end;
  logic          frame_end;
  logic          lit;
  assign slot_end  = p == PW'(SPD - 1);
  assign frame_end = slot_end && idx == 2'd3;
  // the frame before the first shadow capture shows nothing, as does the dark half of a hold blink
  assign lit = loaded && !(sh_hld && !phase) && p >= PW'(GRD);
  // slot position, digit index, frame count and blink phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      p     <= '0;
      idx   <= '0;
      f     <= '0;
      phase <= 1'b1;
    end else begin
      p <= slot_end ? '0 : p + 1'b1;
      if (slot_end) idx <= idx + 1'b1;
      if (frame_end) begin
        f <= f == FW'(BLK - 1) ? '0 : f + 1'b1;
        if (f == FW'(BLK - 1)) phase <= ~phase;
      end
    end
  // latch all inputs only at the frame boundary so one frame never mixes old and new digits
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sh_dig <= '{default: '0};
      sh_run <= 1'b0;
      sh_hld <= 1'b0;
      loaded <= 1'b0;
    end else if (frame_end) begin
      sh_dig <= '{sec_0, sec_1, min_0, min_1};
      sh_run <= s_run;
      sh_hld <= s_hld;
      loaded <= 1'b1;
    end
  // registered display drive from the current scan state; at most one digit enable by construction
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      an  <= '0;
      seg <= '0;
      dp  <= 1'b0;
    end else begin
      an  <= lit ? 4'b0001 << idx : 4'b0000;
      seg <= lit ? sh_dig[idx] : 7'h00;
      dp  <= lit && idx == 2'd2 && sh_run;
    end
endmodule
